// File: rtl/frame_reader_pkg.sv
// frame_reader_pkg: shared types and constants for axi_frame_reader.
//   state_t         address FSM state encoding (IDLE, ADDR, DATA, DRAIN)
//   SIZE_OF_BYTE    bits per byte
//   BURST_BEATS     beats per AXI burst (arlen = BURST_BEATS-1)
//   BURST_BYTES     bytes per burst at 64-bit data width
//   frame_bytes()   bytes in one frame buffer
//   frame_bursts()  bursts needed to read one frame buffer
package frame_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int SIZE_OF_BYTE = 8;
  localparam int BURST_BEATS  = 16;
  localparam int BURST_BYTES  = 128;

  function automatic int frame_bytes(input int w, input int h, input int pix_bytes);
    return w * h * pix_bytes;
  endfunction

  function automatic int frame_bursts(input int w, input int h, input int pix_bytes);
    return frame_bytes(w, h, pix_bytes) / BURST_BYTES;
  endfunction

endpackage

// File: rtl/frame_reader_fifo.sv
// frame_reader_fifo: synchronous beat FIFO with a registered read stage.
//   clk, rst_n     clock and asynchronous active-low reset
//   wr_en/wr_data  push one entry (ignored when full)
//   full/empty     storage status (empty also covers the output register)
//   free_slots     free entries in the storage array
//   rd_valid/data  registered head entry, held until rd_pop
//   rd_pop         consume the head entry
module frame_reader_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free_slots,
  input  logic                     rd_pop,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             wr_fire, load;

  // The output register refills from storage whenever it is empty or being
  // consumed, so a steady stream of pops sees one new entry per cycle.
  always_comb begin
    full        = (count_q == CNT_W'(DEPTH));
    empty       = (count_q == '0) && !out_valid_q;
    free_slots  = CNT_W'(DEPTH) - count_q;
    wr_fire     = wr_en && !full;
    load        = (count_q != '0) && (!out_valid_q || rd_pop);
    wr_ptr_d    = wr_ptr_q + PTR_W'(wr_fire);
    rd_ptr_d    = rd_ptr_q + PTR_W'(load);
    count_d     = count_q + CNT_W'(wr_fire) - CNT_W'(load);
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_q[rd_ptr_q];
    end else if (rd_pop) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Storage needs no reset; emptiness is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_valid = out_valid_q;
  assign rd_data  = out_data_q;

endmodule

// File: rtl/axi_frame_reader.sv
// axi_frame_reader: AXI3 read master that fetches a frame buffer in 16-beat
// INCR bursts and streams it out as 24-bit pixels, two per 64-bit beat.
//   aclk, aresetn   clock and asynchronous active-low reset
//   frame_start     request one frame (one-deep pending while busy)
//   m_axi_ar*/r*    AXI3 read address/data channels, one burst outstanding
//   m_axis_t*       pixel stream; tuser = start of frame, tlast = end of line
//   busy            frame in progress; frame_done one-cycle completion pulse
//   rd_err          sticky read-error flag
// Optional feature macro FRAME_READER_RRESP_CHECK_EN: when defined, a beat
// with rresp != OKAY sets rd_err and its two pixels are output as zero;
// when undefined rresp is ignored and rd_err is tied to 0.
module axi_frame_reader
  import frame_reader_pkg::*;
#(
  parameter int              PIX_SIZE_IN_BYTES = 4,
  parameter int              ADDR_W            = 32,
  parameter int              DATA_W            = 64,
  parameter int              FRAME_W           = 1920,
  parameter int              FRAME_H           = 1080,
  parameter logic [ADDR_W-1:0] ADDR_START      = 'h1000_0000,
  parameter int              FIFO_DEPTH        = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              frame_start,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [3:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic [3:0]        m_axi_arcache,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arlock,
  output logic [3:0]        m_axi_arqos,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [23:0]       m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              frame_done,
  output logic              rd_err
);

  localparam int NUM_BURSTS = frame_bursts(FRAME_W, FRAME_H, PIX_SIZE_IN_BYTES);
  localparam int BIDX_W     = $clog2(NUM_BURSTS + 1);
  localparam int COL_W      = $clog2(FRAME_W + 1);
  localparam int ROW_W      = $clog2(FRAME_H + 1);
  localparam int FCNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int PIX_BITS   = PIX_SIZE_IN_BYTES * SIZE_OF_BYTE;

  if ((FRAME_W % 2) != 0) begin : g_bad_width
    $fatal(1, "axi_frame_reader: FRAME_W must be even");
  end
  if ((frame_bytes(FRAME_W, FRAME_H, PIX_SIZE_IN_BYTES) % BURST_BYTES) != 0) begin : g_bad_size
    $fatal(1, "axi_frame_reader: frame size must be a multiple of 128 bytes");
  end

  state_t            state_q, state_d;
  logic [BIDX_W-1:0] burst_idx_q, burst_idx_d;
  logic              pending_q, pending_d;
  logic              frame_done_q, frame_done_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              half_q, half_d;

  logic              fifo_full, fifo_empty, fifo_pop, fifo_wr_err;
  logic [FCNT_W-1:0] fifo_free;
  logic              fifo_valid;
  logic [DATA_W:0]   fifo_rdata;
  logic              space_ok, ar_fire, r_fire, t_fire, last_pix_fire, beat_err;
  logic [23:0]       pix_data;

  // The error bit rides alongside each beat so the zeroing happens on the
  // pixels that actually came from the faulty beat.
`ifdef FRAME_READER_RRESP_CHECK_EN
  logic rd_err_q, rd_err_d;
  assign fifo_wr_err = (m_axi_rresp != 2'b00);
  assign beat_err    = fifo_rdata[DATA_W];
  assign rd_err_d    = rd_err_q | (r_fire && fifo_wr_err);
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rd_err_q <= 1'b0;
    else          rd_err_q <= rd_err_d;
  end
  assign rd_err = rd_err_q;
  logic unused_ok;
  assign unused_ok = ^{fifo_empty, fifo_rdata};
`else
  assign fifo_wr_err = 1'b0;
  assign beat_err    = 1'b0;
  assign rd_err      = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{fifo_empty, fifo_rdata, m_axi_rresp};
`endif

  frame_reader_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (aclk),
    .rst_n      (aresetn),
    .wr_en      (r_fire),
    .wr_data    ({fifo_wr_err, m_axi_rdata}),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .free_slots (fifo_free),
    .rd_pop     (fifo_pop),
    .rd_valid   (fifo_valid),
    .rd_data    (fifo_rdata)
  );

  assign m_axi_arlen   = 4'(BURST_BEATS - 1);
  assign m_axi_arsize  = 3'($clog2(DATA_W / SIZE_OF_BYTE));
  assign m_axi_arburst = 2'b01;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arqos   = 4'd0;

  // A burst is only requested once the whole burst fits in the FIFO. While
  // waiting in ADDR no beats arrive, so free space only grows and arvalid,
  // once raised, stays up until the handshake.
  always_comb begin
    space_ok      = (fifo_free >= FCNT_W'(BURST_BEATS));
    m_axi_arvalid = (state_q == ST_ADDR) && space_ok;
    m_axi_araddr  = '0;
    if (m_axi_arvalid)
      m_axi_araddr = ADDR_START + (ADDR_W'(burst_idx_q) << $clog2(BURST_BYTES));
    m_axi_rready  = (state_q == ST_DATA) && !fifo_full;
    ar_fire       = m_axi_arvalid && m_axi_arready;
    r_fire        = m_axi_rvalid && m_axi_rready;
  end

  // Stream side: the low pixel of a beat goes out first, the beat is popped
  // after its high pixel is accepted.
  always_comb begin
    pix_data      = half_q ? fifo_rdata[PIX_BITS +: 24] : fifo_rdata[0 +: 24];
    m_axis_tvalid = fifo_valid;
    m_axis_tdata  = '0;
    m_axis_tuser  = 1'b0;
    m_axis_tlast  = 1'b0;
    if (fifo_valid) begin
      m_axis_tdata = beat_err ? 24'h000000 : pix_data;
      m_axis_tuser = (col_q == '0) && (row_q == '0);
      m_axis_tlast = (col_q == COL_W'(FRAME_W - 1));
    end
    t_fire        = m_axis_tvalid && m_axis_tready;
    fifo_pop      = t_fire && half_q;
    last_pix_fire = t_fire && (col_q == COL_W'(FRAME_W - 1)) && (row_q == ROW_W'(FRAME_H - 1));
    half_d = half_q;
    col_d  = col_q;
    row_d  = row_q;
    if (t_fire) begin
      half_d = !half_q;
      if (col_q == COL_W'(FRAME_W - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(FRAME_H - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Address FSM next state. A start seen while a frame runs is remembered
  // once and launched from IDLE right after frame_done.
  always_comb begin
    state_d      = state_q;
    burst_idx_d  = burst_idx_q;
    pending_d    = pending_q;
    frame_done_d = 1'b0;
    if (frame_start && (state_q != ST_IDLE)) pending_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        burst_idx_d = '0;
        if (frame_start || pending_q) begin
          state_d   = ST_ADDR;
          pending_d = 1'b0;
        end
      end
      ST_ADDR: begin
        if (ar_fire) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (r_fire && m_axi_rlast) begin
          burst_idx_d = burst_idx_q + 1'b1;
          state_d     = (burst_idx_q == BIDX_W'(NUM_BURSTS - 1)) ? ST_DRAIN : ST_ADDR;
        end
      end
      ST_DRAIN: begin
        if (last_pix_fire) begin
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      burst_idx_q  <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      half_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_idx_q  <= burst_idx_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      col_q        <= col_d;
      row_q        <= row_d;
      half_q       <= half_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_axi_frame_reader.sv
// tb_axi_frame_reader: self-checking bench for axi_frame_reader on a 32x4
// frame. A zero-wait AXI slave model serves bursts; a frame-level model
// predicts every pixel, its framing flags and the frame_done pulse.
module tb_axi_frame_reader;

  localparam int          W      = 32;
  localparam int          H      = 4;
  localparam int          NPIX   = W * H;
  localparam int          NBURST = NPIX * 4 / 128;
  localparam logic [31:0] BASE   = 32'h1000_0000;
`ifdef FRAME_READER_RRESP_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        aclk, aresetn, frame_start;
  logic [31:0] m_axi_araddr;
  logic [3:0]  m_axi_arlen, m_axi_arcache, m_axi_arqos;
  logic [2:0]  m_axi_arsize, m_axi_arprot;
  logic [1:0]  m_axi_arburst, m_axi_rresp;
  logic        m_axi_arlock, m_axi_arvalid, m_axi_arready;
  logic [63:0] m_axi_rdata;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tuser, m_axis_tlast;
  logic        busy, frame_done, rd_err;

  axi_frame_reader #(
    .FRAME_W (W),
    .FRAME_H (H)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .frame_start   (frame_start),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arcache (m_axi_arcache),
    .m_axi_arprot  (m_axi_arprot),
    .m_axi_arlock  (m_axi_arlock),
    .m_axi_arqos   (m_axi_arqos),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .frame_done    (frame_done),
    .rd_err        (rd_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int total_checks  = 0;
  int passed_checks = 0;

  // Settings written only by the main sequence.
  bit tready_random = 1'b0;
  int ar_delay      = 0;
  int err_beat      = -1;
  int pend_target   = -1;

  // Model state written only by the monitor process.
  int          cycle = 0, pix_cnt = 0, frames_cnt = 0, ar_cnt = 0;
  int          beats_left = 0, next_beat = 0, ar_wait = 0, first_r_cycle = 0;
  bit          r_seen = 0, t_seen = 0, exp_done = 0, chk_next_ar = 0;
  bit          was_stall = 0, ar_waiting = 0;
  logic [23:0] prev_data;
  logic        prev_user, prev_last;
  logic [31:0] prev_araddr;
  int          cur_tuser = 0, cur_tlast = 0, last_tuser = 0, last_tlast = 0;
  logic [31:0] frame_ar [NBURST];
  logic [23:0] frame_pix [8];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total_checks++;
    if (actual === expected) passed_checks++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
  endtask

  // Memory content: pixel p is {FF, p, p^A5, p+3C}; beat 0 is a fixed pattern.
  function automatic logic [23:0] pix24(input int p);
    logic [7:0] b;
    b = 8'(p);
    return {b, b ^ 8'hA5, b + 8'h3C};
  endfunction

  function automatic logic [63:0] beat_val(input int b);
    if (b == 0) return 64'hFF11_2233_FF44_5566;
    return {8'hFF, pix24(2 * b + 1), 8'hFF, pix24(2 * b)};
  endfunction

  function automatic logic [23:0] exp_pix(input int k);
    logic [63:0] v;
    v = beat_val(k / 2);
    if (ERR_EN && (k / 2 == err_beat)) return 24'h000000;
    return (k % 2 == 1) ? v[55:32] : v[23:0];
  endfunction

  task automatic clearModel();
    pix_cnt = 0; ar_cnt = 0; beats_left = 0; next_beat = 0; ar_wait = 0;
    r_seen = 0; t_seen = 0; exp_done = 0; chk_next_ar = 0;
    was_stall = 0; ar_waiting = 0; cur_tuser = 0; cur_tlast = 0;
  endtask

  task automatic sampleCycle();
    logic ar_hs, r_hs, t_hs;
    ar_hs = m_axi_arvalid && m_axi_arready;
    r_hs  = m_axi_rvalid && m_axi_rready;
    t_hs  = m_axis_tvalid && m_axis_tready;

    if (frame_done || exp_done) checkOutput("frame_done", frame_done, exp_done);
    exp_done = 0;
    if (chk_next_ar) begin
      checkOutput("pending_start_arvalid", m_axi_arvalid, 1);
      chk_next_ar = 0;
    end
    if (frame_done && frames_cnt == pend_target) chk_next_ar = 1;

    if (m_axi_rvalid) checkOutput("rready_mid_burst", m_axi_rready, 1);
    if (r_hs) begin
      if (!r_seen) begin r_seen = 1; first_r_cycle = cycle; end
      beats_left--;
      next_beat++;
    end

    if (m_axi_arvalid) checkOutput("ar_single_outstanding", beats_left, 0);
    if (ar_waiting) checkOutput("araddr_hold", {m_axi_arvalid, m_axi_araddr}, {1'b1, prev_araddr});
    ar_waiting  = m_axi_arvalid && !m_axi_arready;
    prev_araddr = m_axi_araddr;
    if (ar_waiting) ar_wait++;
    if (ar_hs) begin
      checkOutput("araddr", m_axi_araddr, BASE + 32'(ar_cnt * 128));
      checkOutput("ar_fields",
        {m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_arprot, m_axi_arlock, m_axi_arqos},
        {4'hF, 3'b011, 2'b01, 4'h0, 3'h0, 1'b0, 4'h0});
      if (ar_cnt < NBURST) frame_ar[ar_cnt] = m_axi_araddr;
      next_beat  = ar_cnt * 16;
      beats_left = 16;
      ar_cnt++;
      ar_wait = 0;
    end

    if (was_stall)
      checkOutput("stall_hold", {m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast},
                  {1'b1, prev_data, prev_user, prev_last});
    if (m_axis_tvalid) begin
      checkOutput("tdata", m_axis_tdata, exp_pix(pix_cnt));
      checkOutput("tuser_tlast", {m_axis_tuser, m_axis_tlast}, {pix_cnt == 0, (pix_cnt % W) == W - 1});
      if (!t_seen) begin
        t_seen = 1;
        checkOutput("first_pixel_latency", cycle - first_r_cycle, 2);
      end
    end
    was_stall = m_axis_tvalid && !m_axis_tready;
    prev_data = m_axis_tdata;
    prev_user = m_axis_tuser;
    prev_last = m_axis_tlast;

    if (t_hs) begin
      if (pix_cnt < 8) frame_pix[pix_cnt] = m_axis_tdata;
      cur_tuser += int'(m_axis_tuser);
      cur_tlast += int'(m_axis_tlast);
      if (pix_cnt == NPIX - 1) begin
        exp_done = 1; frames_cnt++;
        pix_cnt = 0; ar_cnt = 0; next_beat = 0; r_seen = 0; t_seen = 0;
        last_tuser = cur_tuser; last_tlast = cur_tlast;
        cur_tuser = 0; cur_tlast = 0;
      end else begin
        pix_cnt++;
      end
    end
  endtask

  task automatic driveSlave();
    m_axis_tready = tready_random ? 1'($urandom_range(0, 1)) : 1'b1;
    m_axi_arready = aresetn && (ar_wait >= ar_delay);
    if (aresetn && beats_left > 0) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = beat_val(next_beat);
      m_axi_rresp  = (next_beat == err_beat) ? 2'b10 : 2'b00;
      m_axi_rlast  = (beats_left == 1);
    end else begin
      m_axi_rvalid = 1'b0;
      m_axi_rdata  = '0;
      m_axi_rresp  = 2'b00;
      m_axi_rlast  = 1'b0;
    end
  endtask

  // Monitor/slave: observe at the falling edge, drive just after the rising edge.
  initial begin
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0;
    m_axi_rresp = 2'b00; m_axi_rlast = 0; m_axis_tready = 1;
    forever begin
      @(negedge aclk);
      cycle++;
      if (!aresetn) clearModel();
      else sampleCycle();
      @(posedge aclk);
      #1;
      driveSlave();
    end
  end

  task automatic applyStimulus();
    @(posedge aclk); #1 frame_start = 1'b1;
    @(posedge aclk); #1 frame_start = 1'b0;
  endtask

  task automatic waitFrames(input int target, input int budget);
    int n = 0;
    while (frames_cnt < target && n < budget) begin
      @(negedge aclk);
      n++;
    end
    checkOutput("frame_count", frames_cnt, target);
    repeat (3) @(negedge aclk);
  endtask

  task automatic checkResetOutputs();
    checkOutput("reset_axi", {m_axi_arvalid, m_axi_rready, m_axi_araddr}, '0);
    checkOutput("reset_stream", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}, '0);
    checkOutput("reset_status", {busy, frame_done, rd_err}, '0);
  endtask

  initial begin
    int n;
    aresetn = 1'b0;
    frame_start = 1'b0;
    repeat (3) @(negedge aclk);
    checkResetOutputs();
    @(posedge aclk); #1 aresetn = 1'b1;

    $display("[TB] basic frame, zero-wait slave");
    applyStimulus();
    @(negedge aclk);
    checkOutput("arvalid_after_start", m_axi_arvalid, 1);
    checkOutput("busy_in_frame", busy, 1);
    waitFrames(1, 2000);
    checkOutput("ar0", frame_ar[0], 32'h1000_0000);
    checkOutput("ar1", frame_ar[1], 32'h1000_0080);
    checkOutput("ar2", frame_ar[2], 32'h1000_0100);
    checkOutput("ar3", frame_ar[3], 32'h1000_0180);
    checkOutput("pix0_literal", frame_pix[0], 24'h445566);
    checkOutput("pix1_literal", frame_pix[1], 24'h112233);
    checkOutput("tuser_count", last_tuser, 1);
    checkOutput("tlast_count", last_tlast, 4);
    checkOutput("busy_after_frame", busy, 0);

    $display("[TB] random tready, arready delayed 5 cycles");
    tready_random = 1'b1;
    ar_delay = 5;
    applyStimulus();
    waitFrames(2, 4000);
    checkOutput("tlast_count_stalled", last_tlast, 4);
    tready_random = 1'b0;
    ar_delay = 0;

    $display("[TB] pending start");
    pend_target = frames_cnt + 1;
    applyStimulus();
    repeat (20) @(posedge aclk);
    applyStimulus();
    repeat (20) @(posedge aclk);
    applyStimulus();
    waitFrames(4, 4000);
    repeat (300) @(negedge aclk);
    checkOutput("no_third_frame", frames_cnt, 4);
    checkOutput("idle_after_pending", busy, 0);

    $display("[TB] reset mid-burst");
    applyStimulus();
    n = 0;
    while (next_beat < 20 && n < 500) begin
      @(negedge aclk);
      n++;
    end
    checkOutput("midburst_reached", next_beat >= 20, 1);
    @(posedge aclk); #2 aresetn = 1'b0;
    @(negedge aclk);
    checkResetOutputs();
    repeat (2) @(negedge aclk);
    checkResetOutputs();
    @(posedge aclk); #1 aresetn = 1'b1;
    applyStimulus();
    waitFrames(5, 2000);
    checkOutput("ar0_after_reset", frame_ar[0], 32'h1000_0000);
    checkOutput("tuser_after_reset", last_tuser, 1);

    $display("[TB] rresp error on beat 3");
    err_beat = 3;
    applyStimulus();
    waitFrames(6, 2000);
    err_beat = -1;
    checkOutput("err_pix6", frame_pix[6], ERR_EN ? 24'h000000 : 24'h06A342);
    checkOutput("err_pix7", frame_pix[7], ERR_EN ? 24'h000000 : 24'h07A243);
    checkOutput("rd_err_set", rd_err, ERR_EN);
    repeat (10) @(negedge aclk);
    checkOutput("rd_err_sticky", rd_err, ERR_EN);
    @(posedge aclk); #2 aresetn = 1'b0;
    @(negedge aclk);
    checkOutput("rd_err_reset", rd_err, 0);
    @(posedge aclk); #1 aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
